ones_count3_triple: RTL and testbench

- Three-input ones counter. Outputs the 2-bit count of logic-1s on a, b, c.
- y1 is the majority (carry) bit; y0 is the odd-parity (sum) bit. Functionally this is a full adder.
- The block holds three independent implementations of the same function, cross-checks them, and registers the agreed result.
- Serves as the basic switch/gate-structure reference block in the logic-design library.

---
 rtl/ones_count3_triple.sv | 58 +++++
 tb/tb_ones_count3_triple.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ones_count3_triple.sv
// ones_count3_triple: triple-redundant 3-input ones counter with cross-check and registered result
module ones_count3_triple #(
    parameter bit STICKY_ERR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       fault_inj,
    output logic       y1,
    output logic       y0,
    output logic [1:0] y_oc,
    output logic [1:0] y_gate,
    output logic [1:0] count_q,
    output logic       mismatch
);
    logic [2:0] pd_hi;
    logic [3:0] pd_lo;
    logic       oc_hi, oc_lo;
    logic       ab, bc, ac;
    logic       mismatch_now, mismatch_d, mismatch_q;
    logic [1:0] count_d;

    assign y1 = (a & b) | (b & c) | (a & c);
    assign y0 = a ^ b ^ c;

    // each stage pulls its wired-AND net low when active; the pull-up drives 1 otherwise
    assign pd_hi = {~a & ~b, ~b & ~c, ~a & ~c};
    assign pd_lo = {~a & ~b & ~c, ~a & b & c, a & ~b & c, a & b & ~c};
    assign oc_hi = ~|pd_hi;
    assign oc_lo = ~|pd_lo;
    assign y_oc  = {oc_hi, oc_lo ^ fault_inj};

    and g_ab (ab, a, b);
    and g_bc (bc, b, c);
    and g_ac (ac, a, c);
    or  g_y1 (y_gate[1], ab, bc, ac);
    xor g_y0 (y_gate[0], a, b, c);

    always_comb begin
        mismatch_now = (y_oc != y_gate) | (y_gate != {y1, y0});
        count_d      = {y1, y0};
        mismatch_d   = STICKY_ERR ? (mismatch_q | mismatch_now) : mismatch_now;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 2'b00;
            mismatch_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
endmodule

// File: tb/tb_ones_count3_triple.sv
// tb_ones_count3_triple: table-driven check of both STICKY_ERR variants with a scoreboard for registered outputs
module tb_ones_count3_triple;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, fault_inj = 1'b0;
    logic       y1_s, y0_s, y1_n, y0_n, mm_s, mm_n;
    logic [1:0] yoc_s, yg_s, cq_s, yoc_n, yg_n, cq_n;

    typedef struct {
        logic [2:0] abc;
        logic       fi;
        logic [1:0] cnt;
    } vec_t;

    typedef struct {
        logic [1:0] cnt;
        logic       ms;
        logic       mn;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic ms_m = 1'b0;
    logic mn_m = 1'b0;

    ones_count3_triple #(.STICKY_ERR(1'b1)) u_s (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .fault_inj(fault_inj),
        .y1(y1_s), .y0(y0_s), .y_oc(yoc_s), .y_gate(yg_s), .count_q(cq_s), .mismatch(mm_s)
    );

    ones_count3_triple #(.STICKY_ERR(1'b0)) u_n (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .fault_inj(fault_inj),
        .y1(y1_n), .y0(y0_n), .y_oc(yoc_n), .y_gate(yg_n), .count_q(cq_n), .mismatch(mm_n)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_comb(input logic [1:0] cnt, input logic fi);
        check("y1y0_s", {y1_s, y0_s}, cnt);
        check("y1y0_n", {y1_n, y0_n}, cnt);
        check("y_gate_s", yg_s, cnt);
        check("y_gate_n", yg_n, cnt);
        check("y_oc_s", yoc_s, cnt ^ {1'b0, fi});
        check("y_oc_n", yoc_n, cnt ^ {1'b0, fi});
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        {a, b, c} = v.abc;
        fault_inj = v.fi;
        #1;
        check_comb(v.cnt, v.fi);
        ms_m = ms_m | v.fi;
        mn_m = v.fi;
        sb.push_back('{cnt: v.cnt, ms: ms_m, mn: mn_m});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("count_q_s", cq_s, e.cnt);
        check("count_q_n", cq_n, e.cnt);
        check("mismatch_s", {1'b0, mm_s}, {1'b0, e.ms});
        check("mismatch_n", {1'b0, mm_n}, {1'b0, e.mn});
    endtask

    initial begin
        // walk from reset
        tbl.push_back('{3'b000, 1'b0, 2'b00});
        tbl.push_back('{3'b100, 1'b0, 2'b01});
        tbl.push_back('{3'b110, 1'b0, 2'b10});
        tbl.push_back('{3'b111, 1'b0, 2'b11});
        tbl.push_back('{3'b011, 1'b0, 2'b10});
        tbl.push_back('{3'b001, 1'b0, 2'b01});
        tbl.push_back('{3'b000, 1'b0, 2'b00});
        // exhaustive sweep
        tbl.push_back('{3'b000, 1'b0, 2'b00});
        tbl.push_back('{3'b001, 1'b0, 2'b01});
        tbl.push_back('{3'b010, 1'b0, 2'b01});
        tbl.push_back('{3'b011, 1'b0, 2'b10});
        tbl.push_back('{3'b100, 1'b0, 2'b01});
        tbl.push_back('{3'b101, 1'b0, 2'b10});
        tbl.push_back('{3'b110, 1'b0, 2'b10});
        tbl.push_back('{3'b111, 1'b0, 2'b11});
        // fault injection, then release
        tbl.push_back('{3'b001, 1'b1, 2'b01});
        tbl.push_back('{3'b001, 1'b0, 2'b01});
        tbl.push_back('{3'b001, 1'b0, 2'b01});
        tbl.push_back('{3'b111, 1'b0, 2'b11});

        #2;
        check("rst_count_q_s", cq_s, 2'b00);
        check("rst_count_q_n", cq_n, 2'b00);
        check("rst_mismatch_s", {1'b0, mm_s}, 2'b00);
        check("rst_mismatch_n", {1'b0, mm_n}, 2'b00);
        check_comb(2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // asynchronous reset between edges with count_q=11 and sticky flag set
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_count_q_s", cq_s, 2'b00);
        check("async_rst_count_q_n", cq_n, 2'b00);
        check("async_rst_mismatch_s", {1'b0, mm_s}, 2'b00);
        check("async_rst_mismatch_n", {1'b0, mm_n}, 2'b00);
        check_comb(2'b11, 1'b0);
        @(posedge clk);
        #1;
        check("held_rst_count_q_s", cq_s, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        ms_m = 1'b0;
        mn_m = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_count_q_s", cq_s, 2'b11);
        check("post_rst_count_q_n", cq_n, 2'b11);
        check("post_rst_mismatch_s", {1'b0, mm_s}, 2'b00);

        // all inputs rising together
        apply('{3'b000, 1'b0, 2'b00});
        apply('{3'b111, 1'b0, 2'b11});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
